// File: rtl/gauss_array_ctrl_if.sv
// rtl/gauss_array_ctrl_if.sv - job, row stream, PE array and result signals of gauss_array_ctrl
interface gauss_array_ctrl_if #(
   parameter int GF_BIT      = 4,
   parameter int OP_CODE_LEN = 4
);
   logic                   start;
   logic                   abort;
   logic                   busy;
   logic                   done;
   logic                   row_valid;
   logic                   row_ready;
   logic [GF_BIT-1:0]      row_data;
   logic                   arr_en;
   logic                   arr_start;
   logic                   arr_finish;
   logic [OP_CODE_LEN-1:0] arr_op;
   logic [GF_BIT-1:0]      arr_data;
   logic [GF_BIT-1:0]      arr_res_data;
   logic                   res_valid;
   logic [GF_BIT-1:0]      res_data;

   modport slave (
      input  start, abort, row_valid, row_data, arr_res_data,
      output busy, done, row_ready, arr_en, arr_start, arr_finish, arr_op, arr_data,
             res_valid, res_data
   );

   modport master (
      output start, abort, row_valid, row_data, arr_res_data,
      input  busy, done, row_ready, arr_en, arr_start, arr_finish, arr_op, arr_data,
             res_valid, res_data
   );
endinterface

// File: rtl/gauss_array_ctrl.sv
// rtl/gauss_array_ctrl.sv - sequencer for a linear Gaussian-elimination PE array
// Clears the array, streams an N x COLS matrix in, drains it and collects N*COLS results.
module gauss_array_ctrl #(
   parameter int GF_BIT      = 4,
   parameter int OP_CODE_LEN = 4,
   parameter int N           = 16,
   parameter int COLS        = 17
) (
   input logic               clk,
   input logic               rst_n,
   gauss_array_ctrl_if.slave bus
);
   localparam int TOTAL = N * COLS;
   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW    = (N > 1) ? $clog2(N) : 1;
   localparam int TW    = $clog2(TOTAL + 1);
   localparam logic [OP_CODE_LEN-1:0] OP_CLR = OP_CODE_LEN'(3);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, FLUSH, ABORT} state_t;

   state_t         state_q;
   logic [CW-1:0]  col_q;
   logic [RW-1:0]  row_q;
   logic [TW-1:0]  res_cnt_q;
   logic [N-1:0]   tag_q;

   logic                   busy_c;
   logic                   done_c;
   logic                   row_ready_c;
   logic                   arr_en_c;
   logic                   arr_start_c;
   logic                   arr_finish_c;
   logic [OP_CODE_LEN-1:0] arr_op_c;
   logic [GF_BIT-1:0]      arr_data_c;
   logic                   res_valid_c;
   logic [GF_BIT-1:0]      res_data_c;
   logic                   last_elem;
   logic                   abort_hit;

   assign last_elem = (row_q == RW'(N - 1)) && (col_q == CW'(COLS - 1));
   assign abort_hit = bus.abort && (state_q inside {CLEAR, FEED, DRAIN, FLUSH});

   // Outputs decode the registered state so reset clears them without waiting for a clock.
   always_comb begin
      busy_c       = (state_q != IDLE);
      row_ready_c  = 1'b0;
      arr_en_c     = 1'b0;
      arr_start_c  = 1'b0;
      arr_finish_c = 1'b0;
      arr_op_c     = '0;
      arr_data_c   = '0;
      case (state_q)
         CLEAR, ABORT: begin
            arr_en_c = 1'b1;
            arr_op_c = OP_CLR;
         end
         FEED: begin
            row_ready_c = 1'b1;
            arr_en_c    = bus.row_valid;
            arr_data_c  = bus.row_data;
            arr_start_c = bus.row_valid && (col_q == '0);
         end
         DRAIN: begin
            arr_en_c     = 1'b1;
            arr_finish_c = 1'b1;
            arr_start_c  = (col_q == '0);
         end
         FLUSH: arr_en_c = 1'b1;
         default: ;
      endcase
      res_valid_c = tag_q[N-1] & arr_en_c;
      res_data_c  = res_valid_c ? bus.arr_res_data : '0;
      done_c      = res_valid_c && (res_cnt_q == TW'(TOTAL - 1)) && !bus.abort;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         res_cnt_q <= '0;
         tag_q     <= '0;
      end else if (abort_hit || state_q == ABORT || done_c) begin
         state_q   <= abort_hit ? ABORT : IDLE;
         col_q     <= '0;
         row_q     <= '0;
         res_cnt_q <= '0;
         tag_q     <= '0;
      end else begin
         // The tag line mirrors the array pipeline: it only moves when the array is enabled.
         if (arr_en_c) tag_q <= {tag_q[N-2:0], arr_finish_c};
         if (res_valid_c) res_cnt_q <= res_cnt_q + TW'(1);
         case (state_q)
            IDLE:  if (bus.start && !bus.abort) state_q <= CLEAR;
            CLEAR: state_q <= FEED;
            FEED, DRAIN: begin
               if (arr_en_c) begin
                  if (col_q == CW'(COLS - 1)) begin
                     col_q <= '0;
                     row_q <= (row_q == RW'(N - 1)) ? '0 : row_q + RW'(1);
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
                  if (last_elem) state_q <= (state_q == FEED) ? DRAIN : FLUSH;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.row_ready  = row_ready_c;
   assign bus.arr_en     = arr_en_c;
   assign bus.arr_start  = arr_start_c;
   assign bus.arr_finish = arr_finish_c;
   assign bus.arr_op     = arr_op_c;
   assign bus.arr_data   = arr_data_c;
   assign bus.res_valid  = res_valid_c;
   assign bus.res_data   = res_data_c;
endmodule

// File: tb/tb_gauss_array_ctrl.sv
// tb/tb_gauss_array_ctrl.sv - self-checking bench for gauss_array_ctrl with N=4, COLS=5, GF(16)
module tb_gauss_array_ctrl;
   localparam int NN = 4;
   localparam int CC = 5;
   localparam int TOTAL = NN * CC;
   localparam int P_IDLE = 0, P_CLEAR = 1, P_FEED = 2, P_DRAIN = 3, P_FLUSH = 4, P_ABORT = 5;

   logic clk;
   logic rst_n;
   int checks;
   int failures;

   gauss_array_ctrl_if #(.GF_BIT(4), .OP_CODE_LEN(4)) bus ();

   gauss_array_ctrl #(.GF_BIT(4), .OP_CODE_LEN(4), .N(NN), .COLS(CC)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // per-job observations
   int n_op3, n_feed, n_res, n_done, n_stall, first_res, drain_cyc, acc_idx;
   int busy_after_done, n_op3_post, n_res_post, starts_enc, n_starts;
   bit prev_done, abort_seen;

   // reference model: job phase plus element / drain / flush counts
   int ph, mk, md, mf;

   function automatic logic [18:0] outs();
      return {bus.busy, bus.done, bus.row_ready, bus.arr_en, bus.arr_start, bus.arr_finish,
              bus.arr_op, bus.arr_data, bus.res_valid, bus.res_data};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      n_op3 = 0; n_feed = 0; n_res = 0; n_done = 0; n_stall = 0; first_res = -1;
      drain_cyc = -1; acc_idx = 0; busy_after_done = -1; n_op3_post = 0; n_res_post = 0;
      starts_enc = 0; n_starts = 0; prev_done = 0; abort_seen = 0;
   endtask

   always @(negedge clk) begin
      bit eb, ed, er, ee, es, ef, erv;
      logic [3:0] eop, edat, erd;
      eb = 0; ed = 0; er = 0; ee = 0; es = 0; ef = 0; erv = 0;
      eop = 0; edat = 0; erd = 0;
      if (!rst_n) begin
         ph = P_IDLE; mk = 0; md = 0; mf = 0;
      end else begin
         case (ph)
            P_CLEAR, P_ABORT: begin eb = 1; ee = 1; eop = 4'd3; end
            P_FEED: begin
               eb = 1; er = 1; ee = bus.row_valid; edat = bus.row_data;
               es = bus.row_valid && (mk % CC == 0);
            end
            P_DRAIN: begin
               eb = 1; ee = 1; ef = 1; es = (md % CC == 0); erv = (md >= NN);
            end
            P_FLUSH: begin
               eb = 1; ee = 1; erv = 1; ed = (mf == NN - 1) && !bus.abort;
            end
            default: ;
         endcase
         if (erv) erd = bus.arr_res_data;
      end
      chk("cycle_outputs", int'(outs()), int'({eb, ed, er, ee, es, ef, eop, edat, erv, erd}));

      if (rst_n) begin
         if (abort_seen && bus.arr_op == 4'd3) n_op3_post++;
         if (abort_seen && bus.res_valid) n_res_post++;
         if (bus.abort && bus.busy) abort_seen = 1;
         if (bus.arr_op == 4'd3) n_op3++;
         if (bus.row_ready) n_feed++;
         if (bus.row_ready && !bus.arr_en) n_stall++;
         if (bus.arr_start && bus.row_ready) begin
            starts_enc = starts_enc * 32 + acc_idx; n_starts++;
         end
         if (bus.row_ready && bus.row_valid) acc_idx++;
         if (bus.arr_finish && drain_cyc < 0) drain_cyc = 0;
         if (bus.res_valid && first_res < 0) first_res = drain_cyc;
         if (drain_cyc >= 0) drain_cyc++;
         if (bus.res_valid) n_res++;
         if (bus.done) n_done++;
         if (prev_done) busy_after_done = int'(bus.busy);
         prev_done = bus.done;

         case (ph)
            P_IDLE: if (bus.start && !bus.abort) ph = P_CLEAR;
            P_CLEAR: begin ph = bus.abort ? P_ABORT : P_FEED; mk = 0; end
            P_FEED: begin
               if (bus.abort) ph = P_ABORT;
               else if (bus.row_valid) begin
                  mk++;
                  if (mk == TOTAL) begin ph = P_DRAIN; md = 0; end
               end
            end
            P_DRAIN: begin
               if (bus.abort) ph = P_ABORT;
               else begin
                  md++;
                  if (md == TOTAL) begin ph = P_FLUSH; mf = 0; end
               end
            end
            P_FLUSH: begin
               if (bus.abort) ph = P_ABORT;
               else begin
                  mf++;
                  if (mf == NN) ph = P_IDLE;
               end
            end
            default: ph = P_IDLE;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      bus.arr_res_data = 4'($urandom);
   endtask

   task automatic do_job(input int stall_at, input int abort_d, input int rst_e,
                         input bit rand_valid, input bit start_busy);
      int e, d, stalls, cyc;
      bit acc, fin;
      clear_stats();
      e = 0; d = 0; stalls = 0;
      bus.start = 1;
      step();
      bus.start = 0;
      for (cyc = 0; cyc < 400; cyc++) begin
         bus.row_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (stall_at >= 0 && e == stall_at && bus.row_ready && stalls < 3) begin
            bus.row_valid = 0; stalls++;
         end
         bus.row_data = 4'(e + 1);
         bus.start = start_busy && (e == 3) && bus.row_ready;
         bus.abort = (abort_d >= 0) && bus.arr_finish && (d == abort_d);
         if (rst_e >= 0 && e == rst_e && bus.row_ready) begin
            #2 rst_n = 0;
            #1 chk("async_reset_outputs", int'(outs()), 0);
            @(posedge clk);
            #1 rst_n = 1;
            chk("idle_after_reset_busy", int'(bus.busy), 0);
            break;
         end
         @(negedge clk);
         acc = bus.row_valid && bus.row_ready;
         fin = bus.arr_finish;
         step();
         if (acc) e++;
         if (fin) d++;
         if (!bus.busy) break;
      end
      if (cyc >= 400) chk("job_timeout", cyc, 0);
      bus.row_valid = 0; bus.start = 0; bus.abort = 0;
      step();
   endtask

   initial begin
      checks = 0; failures = 0;
      ph = P_IDLE; mk = 0; md = 0; mf = 0;
      clear_stats();
      bus.start = 0; bus.abort = 0; bus.row_valid = 0; bus.row_data = 0; bus.arr_res_data = 0;
      rst_n = 0;
      #1 chk("reset_outputs", int'(outs()), 0);
      repeat (3) step();
      rst_n = 1;
      step();

      do_job(-1, -1, -1, 0, 1);
      chk("clear_op_cycles", n_op3, 1);
      chk("start_count", n_starts, 4);
      chk("start_positions", starts_enc, 5455);
      chk("feed_cycles", n_feed, 20);
      chk("result_pulses", n_res, 20);
      chk("first_result_drain_cycle", first_res, 4);
      chk("done_pulses", n_done, 1);
      chk("busy_after_done", busy_after_done, 0);

      do_job(7, -1, -1, 0, 0);
      chk("stall_cycles", n_stall, 3);
      chk("stall_start_positions", starts_enc, 5455);
      chk("stall_result_pulses", n_res, 20);
      chk("stall_done_pulses", n_done, 1);

      bus.start = 1; bus.abort = 1;
      step();
      bus.start = 0; bus.abort = 0;
      chk("start_abort_idle_busy", int'(bus.busy), 0);
      step();
      chk("start_abort_idle_busy2", int'(bus.busy), 0);

      do_job(-1, 6, -1, 0, 0);
      chk("abort_clear_cycles", n_op3_post, 1);
      chk("abort_done_pulses", n_done, 0);
      chk("abort_results_after", n_res_post, 0);
      chk("abort_results_before", n_res, 3);

      do_job(-1, -1, 9, 0, 0);
      chk("reset_job_done_pulses", n_done, 0);

      for (int j = 0; j < 3; j++) begin
         do_job(-1, -1, -1, 1, 0);
         chk("rand_result_pulses", n_res, 20);
         chk("rand_done_pulses", n_done, 1);
         chk("rand_busy_after_done", busy_after_done, 0);
         chk("rand_first_result", first_res, 4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gauss_array_ctrl.md
GAUSS_ARRAY_CTRL -- requirements
Module: gauss_array_ctrl

Interface
REQ-001 SHALL take parameter GF_BIT, default 4, meaning field element width (4 = GF(16), 8 = GF(256)).
REQ-002 SHALL take parameter OP_CODE_LEN, default 4, meaning array opcode width.
REQ-003 SHALL take parameter N, default 16, meaning number of rows and number of processing elements in the linear array.
REQ-004 SHALL take parameter COLS, default 17, meaning elements per row (augmented matrix).
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: job request pulse.
REQ-008 SHALL have port abort, input, 1 bit: cancel current job.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a job completes.
REQ-011 SHALL have ports row_valid (input, 1 bit), row_ready (output, 1 bit) and row_data (input, GF_BIT): element-serial, row-major matrix input.
REQ-012 SHALL have ports arr_en (output, 1 bit) and arr_start (output, 1 bit): array clock enable and first-column marker.
REQ-013 SHALL have ports arr_finish (output, 1 bit), arr_op (output, OP_CODE_LEN) and arr_data (output, GF_BIT): drain marker, opcode and data into PE 0.
REQ-014 SHALL have port arr_res_data, input, GF_BIT: data_out of PE N-1.
REQ-015 SHALL have ports res_valid (output, 1 bit) and res_data (output, GF_BIT): result stream with no backpressure.

Function
REQ-016 SHALL implement the states IDLE, CLEAR, FEED, DRAIN, FLUSH and ABORT.
REQ-017 In IDLE, start with abort low SHALL move the FSM to CLEAR, and start SHALL be ignored in every other state.
REQ-018 CLEAR SHALL last 1 cycle: arr_en=1, arr_op=3 (zero all PE r registers), arr_data=0, then FEED.
REQ-019 In FEED, row_ready SHALL be 1 and arr_op SHALL be 0; arr_en SHALL equal row_valid and arr_data SHALL equal row_data.
REQ-020 In FEED, when row_valid is low, arr_en SHALL be 0 and all counters SHALL hold.
REQ-021 In FEED, col_cnt SHALL step 0..COLS-1 and then wrap to 0, incrementing row_cnt on the wrap.
REQ-022 In FEED, arr_start SHALL be 1 on each accepted element with col_cnt==0.
REQ-023 After N*COLS accepted elements (row_cnt==N-1, col_cnt==COLS-1), the FSM SHALL move to DRAIN.
REQ-024 In DRAIN, outputs SHALL be row_ready=0, arr_en=1, arr_finish=1, arr_data=0, arr_op=0.
REQ-025 In DRAIN, arr_start SHALL be 1 at col_cnt==0, and the FSM SHALL issue N*COLS cycles before moving to FLUSH.
REQ-026 In FLUSH, outputs SHALL be arr_en=1, arr_finish=0, arr_data=0, for N cycles.
REQ-027 A finish tag SHALL enter an N-deep shift register with each arr_en cycle and shift only when arr_en=1.
REQ-028 res_valid SHALL equal the tag leaving the shift register ANDed with arr_en, so the latency from drained element to result is exactly N enabled cycles.
REQ-029 res_data SHALL equal arr_res_data when res_valid=1, and 0 otherwise.
REQ-030 A result counter SHALL count res_valid pulses; when it reaches N*COLS the FSM SHALL pulse done for 1 cycle, return to IDLE and drop busy in the same cycle.
REQ-031 In FEED, DRAIN and FLUSH, abort SHALL move the FSM to ABORT.
REQ-032 ABORT SHALL drive arr_en=1 and arr_op=3 for 1 cycle, clear all counters and the tag register, then go to IDLE without a done pulse.
REQ-033 abort and start high in the same IDLE cycle SHALL leave the FSM in IDLE, because abort wins.
REQ-034 abort during CLEAR SHALL move the FSM to ABORT.
REQ-035 Counters SHALL be sized $clog2 of their maximum value plus 1, with no overflow and no wrap beyond the limits stated above.
REQ-036 Outside the states listed above, arr_op SHALL be 0.

Reset
REQ-037 rst_n low SHALL immediately force state IDLE and zero all counters and the tag register.
REQ-038 rst_n low SHALL immediately force every output to 0: busy, done, row_ready, arr_en, arr_start, arr_finish, arr_op, arr_data, res_valid, res_data.
REQ-039 Reset asserted mid-job SHALL discard the job, and the first cycle after release SHALL be IDLE with no done pulse.

Verification (N=4, COLS=5, GF_BIT=4)
REQ-040 Bench SHALL check: start with row_valid held 1 and 20 elements 1..15,0..4 -> one arr_op=3 cycle, then arr_start on elements 0, 5, 10 and 15, and DRAIN entered after exactly 20 FEED cycles.
REQ-041 Bench SHALL check: row_valid low for 3 cycles at element 7 -> arr_en=0 for those 3 cycles, col_cnt held at 2, and no arr_start.
REQ-042 Bench SHALL check: full job -> exactly 20 res_valid pulses, the first 4 enabled cycles after DRAIN entry, done pulsed once after the last one, and busy=0 in the cycle after done.
REQ-043 Bench SHALL check: start while busy -> no effect; start and abort together in IDLE -> busy stays 0.
REQ-044 Bench SHALL check: abort at DRAIN cycle 6 -> 1 cycle with arr_op=3, then IDLE, with no done and no further res_valid.
REQ-045 Bench SHALL check: rst_n low at FEED element 9 -> all outputs 0 asynchronously, and a new start afterwards runs a complete job correctly.
